// File: rtl/rca_reg_config_bank_if.sv
// Config, commit and lookup bus of the RCA register mapping bank.
// master = CPU/issue side, slave = rca_reg_config_bank.
interface rca_reg_config_bank_if #(
  parameter int NUM_RCAS        = 4,
  parameter int NUM_READ_PORTS  = 5,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int REG_ADDR_W      = 5
);
  localparam int RSEL_W =
    (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;
  localparam int MAXP =
    (NUM_READ_PORTS > NUM_WRITE_PORTS) ?
    NUM_READ_PORTS : NUM_WRITE_PORTS;
  localparam int PSEL_W =
    (MAXP > 1) ? $clog2(MAXP) : 1;

  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [RSEL_W-1:0]      cfg_rca_sel;
  logic                   cfg_src_dest;
  logic [PSEL_W-1:0]      cfg_port_sel;
  logic [REG_ADDR_W-1:0]  cfg_reg_addr;
  logic                   cfg_err;

  logic                   commit_valid;
  logic [RSEL_W-1:0]      commit_rca_sel;
  logic                   commit_ready;

  logic                   lookup_valid;
  logic [RSEL_W-1:0]      lookup_rca_sel;
  logic                   lookup_out_valid;
  logic [NUM_READ_PORTS*REG_ADDR_W-1:0]
                          lookup_src_addrs;
  logic [NUM_WRITE_PORTS*REG_ADDR_W-1:0]
                          lookup_dest_addrs;

  modport master (
    output cfg_valid, cfg_rca_sel,
    output cfg_src_dest, cfg_port_sel,
    output cfg_reg_addr,
    output commit_valid, commit_rca_sel,
    output lookup_valid, lookup_rca_sel,
    input  cfg_ready, cfg_err,
    input  commit_ready,
    input  lookup_out_valid,
    input  lookup_src_addrs,
    input  lookup_dest_addrs
  );

  modport slave (
    input  cfg_valid, cfg_rca_sel,
    input  cfg_src_dest, cfg_port_sel,
    input  cfg_reg_addr,
    input  commit_valid, commit_rca_sel,
    input  lookup_valid, lookup_rca_sel,
    output cfg_ready, cfg_err,
    output commit_ready,
    output lookup_out_valid,
    output lookup_src_addrs,
    output lookup_dest_addrs
  );
endinterface

// File: rtl/rca_reg_config_bank.sv
// Per-RCA register address mapping bank with registered lookup.
// RCA_CFG_SHADOW_EN: staging bank + idle-gated commit to active.
module rca_reg_config_bank #(
  parameter int NUM_RCAS        = 4,
  parameter int NUM_READ_PORTS  = 5,
  parameter int NUM_WRITE_PORTS = 2,
  parameter int REG_ADDR_W      = 5
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_RCAS-1:0] rca_busy_i,
  output logic [NUM_RCAS-1:0] dirty_o,
  rca_reg_config_bank_if.slave bus
);
  localparam int SRC_W = NUM_READ_PORTS * REG_ADDR_W;
  localparam int DST_W = NUM_WRITE_PORTS * REG_ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DONE = 2'd3;
`ifdef RCA_CFG_SHADOW_EN
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_COPY = 2'd2;
  localparam int RSEL_W =
    (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;
`endif

  typedef logic [REG_ADDR_W-1:0] addr_t;

  addr_t act_src_q [NUM_RCAS][NUM_READ_PORTS];
  addr_t act_dst_q [NUM_RCAS][NUM_WRITE_PORTS];

`ifdef RCA_CFG_SHADOW_EN
  addr_t stg_src_q [NUM_RCAS][NUM_READ_PORTS];
  addr_t stg_dst_q [NUM_RCAS][NUM_WRITE_PORTS];
  logic [NUM_RCAS-1:0] dirty_q;
  logic [NUM_RCAS-1:0] lat_oh;
  logic [NUM_RCAS-1:0] copy_oh;
  logic [RSEL_W-1:0]   sel_q, sel_d;
  logic                lat_busy;
`else
  logic                unused_commit_sel;
`endif

  logic [1:0]                 state_q, state_d;
  logic [NUM_RCAS-1:0]        cfg_oh;
  logic [NUM_RCAS-1:0]        lk_oh;
  logic [NUM_READ_PORTS-1:0]  src_oh;
  logic [NUM_WRITE_PORTS-1:0] dst_oh;
  logic                       cfg_fire;
  logic                       port_ok;
  logic                       wr_en;
  logic                       err_q;
  logic                       lk_vld_q;
  logic [SRC_W-1:0]           lk_src_d, lk_src_q;
  logic [DST_W-1:0]           lk_dst_d, lk_dst_q;

  // Out-of-range selects decode to all-zero one-hots.
  always_comb begin
    cfg_oh = '0;
    lk_oh  = '0;
    src_oh = '0;
    dst_oh = '0;
    for (int r = 0; r < NUM_RCAS; r++) begin
      cfg_oh[r] = (32'(bus.cfg_rca_sel) == r);
      lk_oh[r]  = (32'(bus.lookup_rca_sel) == r);
    end
    for (int p = 0; p < NUM_READ_PORTS; p++)
      src_oh[p] = !bus.cfg_src_dest &&
                  (32'(bus.cfg_port_sel) == p);
    for (int p = 0; p < NUM_WRITE_PORTS; p++)
      dst_oh[p] = bus.cfg_src_dest &&
                  (32'(bus.cfg_port_sel) == p);
  end

  assign port_ok  = (|src_oh) | (|dst_oh);
  assign cfg_fire = bus.cfg_valid & bus.cfg_ready;
  assign wr_en    = cfg_fire & port_ok & (|cfg_oh);

`ifdef RCA_CFG_SHADOW_EN
  always_comb begin
    lat_oh = '0;
    for (int r = 0; r < NUM_RCAS; r++)
      lat_oh[r] = (32'(sel_q) == r);
  end

  assign copy_oh  = (state_q == S_COPY) ? lat_oh : '0;
  assign lat_busy = |(rca_busy_i & lat_oh);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUM_RCAS; r++) begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
          stg_src_q[r][p] <= '0;
          act_src_q[r][p] <= '0;
        end
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
          stg_dst_q[r][p] <= '0;
          act_dst_q[r][p] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < NUM_RCAS; r++) begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
          if (wr_en && cfg_oh[r] && src_oh[p])
            stg_src_q[r][p] <= bus.cfg_reg_addr;
          if (copy_oh[r])
            act_src_q[r][p] <= stg_src_q[r][p];
        end
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
          if (wr_en && cfg_oh[r] && dst_oh[p])
            stg_dst_q[r][p] <= bus.cfg_reg_addr;
          if (copy_oh[r])
            act_dst_q[r][p] <= stg_dst_q[r][p];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dirty_q <= '0;
    end else begin
      dirty_q <= (dirty_q & ~copy_oh) |
                 (wr_en ? cfg_oh : '0);
    end
  end

  assign dirty_o       = dirty_q;
  assign bus.cfg_ready = (state_q == S_IDLE);
`else
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUM_RCAS; r++) begin
        for (int p = 0; p < NUM_READ_PORTS; p++)
          act_src_q[r][p] <= '0;
        for (int p = 0; p < NUM_WRITE_PORTS; p++)
          act_dst_q[r][p] <= '0;
      end
    end else begin
      for (int r = 0; r < NUM_RCAS; r++) begin
        for (int p = 0; p < NUM_READ_PORTS; p++)
          if (wr_en && cfg_oh[r] && src_oh[p])
            act_src_q[r][p] <= bus.cfg_reg_addr;
        for (int p = 0; p < NUM_WRITE_PORTS; p++)
          if (wr_en && cfg_oh[r] && dst_oh[p])
            act_dst_q[r][p] <= bus.cfg_reg_addr;
      end
    end
  end

  // Writes land in active, so never touch an RCA in use.
  assign dirty_o       = '0;
  assign bus.cfg_ready = (state_q == S_IDLE) &
                         ~|(rca_busy_i & cfg_oh);
  assign unused_commit_sel = ^bus.commit_rca_sel;
`endif

  always_comb begin
    state_d = state_q;
`ifdef RCA_CFG_SHADOW_EN
    sel_d = sel_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.commit_valid) begin
`ifdef RCA_CFG_SHADOW_EN
          state_d = S_WAIT;
          sel_d   = bus.commit_rca_sel;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef RCA_CFG_SHADOW_EN
      S_WAIT: begin
        if (!lat_busy)
          state_d = S_COPY;
      end
      S_COPY: state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
`ifdef RCA_CFG_SHADOW_EN
      sel_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= cfg_fire & ~port_ok;
`ifdef RCA_CFG_SHADOW_EN
      sel_q   <= sel_d;
`endif
    end
  end

  assign bus.cfg_err      = err_q;
  assign bus.commit_ready = (state_q == S_DONE);

  // Lookup reads active before any same-edge copy lands.
  always_comb begin
    lk_src_d = '0;
    lk_dst_d = '0;
    for (int r = 0; r < NUM_RCAS; r++) begin
      if (lk_oh[r]) begin
        for (int p = 0; p < NUM_READ_PORTS; p++)
          lk_src_d[p*REG_ADDR_W +: REG_ADDR_W] =
            act_src_q[r][p];
        for (int p = 0; p < NUM_WRITE_PORTS; p++)
          lk_dst_d[p*REG_ADDR_W +: REG_ADDR_W] =
            act_dst_q[r][p];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lk_vld_q <= 1'b0;
      lk_src_q <= '0;
      lk_dst_q <= '0;
    end else begin
      lk_vld_q <= bus.lookup_valid;
      if (bus.lookup_valid) begin
        lk_src_q <= lk_src_d;
        lk_dst_q <= lk_dst_d;
      end
    end
  end

  assign bus.lookup_out_valid  = lk_vld_q;
  assign bus.lookup_src_addrs  = lk_src_q;
  assign bus.lookup_dest_addrs = lk_dst_q;
endmodule

// File: tb/tb_rca_reg_config_bank.sv
// Directed bench for rca_reg_config_bank, default parameters.
// Covers both RCA_CFG_SHADOW_EN builds.
module tb_rca_reg_config_bank;
`ifdef RCA_CFG_SHADOW_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  localparam logic [24:0] R1A =
    {5'd0, 5'd0, 5'd0, 5'd0, 5'd4};
  localparam logic [24:0] R1B =
    {5'd31, 5'd0, 5'd0, 5'd0, 5'd4};
  localparam logic [9:0]  D2  = {5'd9, 5'd0};
  localparam logic [3:0]  DA  = SH ? 4'b0010 : 4'b0000;
  localparam logic [3:0]  DB  = SH ? 4'b0110 : 4'b0000;

  typedef struct {
    logic        cv;
    logic [1:0]  cr;
    logic        sd;
    logic [2:0]  cp;
    logic [4:0]  ca;
    logic        lv;
    logic [1:0]  lr;
    logic        e_err;
    logic        e_lov;
    logic [24:0] e_src;
    logic [9:0]  e_dst;
    logic [3:0]  e_dirty;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] busy;
  logic [3:0] dirty;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         n;
  vec_t       tbl [9];

  rca_reg_config_bank_if bus_if ();

  rca_reg_config_bank dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rca_busy_i (busy),
    .dirty_o    (dirty),
    .bus        (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] r,
                           input logic       sd,
                           input logic [2:0] p,
                           input logic [4:0] a);
    bus_if.cfg_valid    = 1'b1;
    bus_if.cfg_rca_sel  = r;
    bus_if.cfg_src_dest = sd;
    bus_if.cfg_port_sel = p;
    bus_if.cfg_reg_addr = a;
    tick();
    bus_if.cfg_valid    = 1'b0;
  endtask

  task automatic lookup(input logic [1:0] r);
    bus_if.lookup_valid   = 1'b1;
    bus_if.lookup_rca_sel = r;
    tick();
    bus_if.lookup_valid   = 1'b0;
  endtask

  task automatic commit_wait(input logic [1:0] r,
                             output int cyc);
    bus_if.commit_valid   = 1'b1;
    bus_if.commit_rca_sel = r;
    cyc = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      cyc = k;
      bus_if.commit_valid = 1'b0;
      if (bus_if.commit_ready) break;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cfg_ready"}, 32'(bus_if.cfg_ready), 1);
    chk({tag, "_cfg_err"}, 32'(bus_if.cfg_err), 0);
    chk({tag, "_commit_rdy"},
        32'(bus_if.commit_ready), 0);
    chk({tag, "_lov"}, 32'(bus_if.lookup_out_valid), 0);
    chk({tag, "_src"}, 32'(bus_if.lookup_src_addrs), 0);
    chk({tag, "_dst"}, 32'(bus_if.lookup_dest_addrs), 0);
    chk({tag, "_dirty"}, 32'(dirty), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    busy  = '0;
    bus_if.cfg_valid      = 1'b0;
    bus_if.cfg_rca_sel    = '0;
    bus_if.cfg_src_dest   = 1'b0;
    bus_if.cfg_port_sel   = '0;
    bus_if.cfg_reg_addr   = '0;
    bus_if.commit_valid   = 1'b0;
    bus_if.commit_rca_sel = '0;
    bus_if.lookup_valid   = 1'b0;
    bus_if.lookup_rca_sel = '0;

    tbl[0] = '{1'b1, 2'd1, 1'b0, 3'd0, 5'd4,
               1'b0, 2'd0,
               1'b0, 1'b0, 25'd0, 10'd0, DA};
    tbl[1] = '{1'b0, 2'd0, 1'b0, 3'd0, 5'd0,
               1'b1, 2'd1,
               1'b0, 1'b1, SH ? 25'd0 : R1A, 10'd0, DA};
    tbl[2] = '{1'b1, 2'd1, 1'b0, 3'd4, 5'd31,
               1'b1, 2'd1,
               1'b0, 1'b1, SH ? 25'd0 : R1A, 10'd0, DA};
    tbl[3] = '{1'b0, 2'd0, 1'b0, 3'd0, 5'd0,
               1'b1, 2'd1,
               1'b0, 1'b1, SH ? 25'd0 : R1B, 10'd0, DA};
    tbl[4] = '{1'b1, 2'd2, 1'b1, 3'd1, 5'd9,
               1'b0, 2'd0,
               1'b0, 1'b0, SH ? 25'd0 : R1B, 10'd0, DB};
    tbl[5] = '{1'b0, 2'd0, 1'b0, 3'd0, 5'd0,
               1'b1, 2'd2,
               1'b0, 1'b1, 25'd0, SH ? 10'd0 : D2, DB};
    tbl[6] = '{1'b1, 2'd0, 1'b0, 3'd6, 5'd7,
               1'b1, 2'd0,
               1'b1, 1'b1, 25'd0, 10'd0, DB};
    tbl[7] = '{1'b1, 2'd3, 1'b1, 3'd2, 5'd3,
               1'b0, 2'd0,
               1'b1, 1'b0, 25'd0, 10'd0, DB};
    tbl[8] = '{1'b0, 2'd0, 1'b0, 3'd0, 5'd0,
               1'b0, 2'd0,
               1'b0, 1'b0, 25'd0, 10'd0, DB};

    tick();
    tick();
    chk_reset("rst");
    rst_n = 1'b1;

`ifdef RCA_CFG_SHADOW_EN
    cfg_write(2'd1, 1'b0, 3'd0, 5'd12);
    bus_if.commit_valid   = 1'b1;
    bus_if.commit_rca_sel = 2'd1;
    busy = 4'b0010;
    tick();
    bus_if.commit_valid = 1'b0;
    tick();
    tick();
    chk("abort_pre_rdy", 32'(bus_if.commit_ready), 0);
    chk("abort_pre_cfgrdy", 32'(bus_if.cfg_ready), 0);
    chk("abort_pre_dirty", 32'(dirty), 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("abort");
    busy = '0;
    #1;
    rst_n = 1'b1;
    tick();
    tick();
    chk("abort_post_rdy", 32'(bus_if.commit_ready), 0);
    chk("abort_post_cfgrdy", 32'(bus_if.cfg_ready), 1);
    lookup(2'd1);
    chk("abort_lk_lov", 32'(bus_if.lookup_out_valid), 1);
    chk("abort_lk_src", 32'(bus_if.lookup_src_addrs), 0);
`endif

    for (int i = 0; i < 9; i++) begin
      bus_if.cfg_valid      = tbl[i].cv;
      bus_if.cfg_rca_sel    = tbl[i].cr;
      bus_if.cfg_src_dest   = tbl[i].sd;
      bus_if.cfg_port_sel   = tbl[i].cp;
      bus_if.cfg_reg_addr   = tbl[i].ca;
      bus_if.lookup_valid   = tbl[i].lv;
      bus_if.lookup_rca_sel = tbl[i].lr;
      tick();
      chk($sformatf("v%0d_err", i),
          32'(bus_if.cfg_err), 32'(tbl[i].e_err));
      chk($sformatf("v%0d_lov", i),
          32'(bus_if.lookup_out_valid), 32'(tbl[i].e_lov));
      chk($sformatf("v%0d_src", i),
          32'(bus_if.lookup_src_addrs), 32'(tbl[i].e_src));
      chk($sformatf("v%0d_dst", i),
          32'(bus_if.lookup_dest_addrs), 32'(tbl[i].e_dst));
      chk($sformatf("v%0d_dirty", i),
          32'(dirty), 32'(tbl[i].e_dirty));
    end
    bus_if.cfg_valid    = 1'b0;
    bus_if.lookup_valid = 1'b0;

`ifdef RCA_CFG_SHADOW_EN
    cfg_write(2'd2, 1'b0, 3'd3, 5'd17);
    chk("s1_dirty_pre", 32'(dirty), 4'b0110);
    commit_wait(2'd2, n);
    chk("s1_latency", 32'(n), 3);
    chk("s1_dirty_post", 32'(dirty), 4'b0010);
    chk("s1_cfgrdy_done", 32'(bus_if.cfg_ready), 0);
    tick();
    chk("s1_cfgrdy_idle", 32'(bus_if.cfg_ready), 1);
    chk("s1_rdy_drop", 32'(bus_if.commit_ready), 0);
    lookup(2'd2);
    chk("s1_src_p3",
        32'(bus_if.lookup_src_addrs[19:15]), 17);
    chk("s1_src", 32'(bus_if.lookup_src_addrs),
        32'({5'd0, 5'd17, 15'd0}));
    chk("s1_dst", 32'(bus_if.lookup_dest_addrs), 32'(D2));

    cfg_write(2'd0, 1'b1, 3'd1, 5'd9);
    chk("s2_dirty_pre", 32'(dirty), 4'b0011);
    bus_if.commit_valid   = 1'b1;
    bus_if.commit_rca_sel = 2'd0;
    busy = 4'b0001;
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      n = k;
      if (k == 1) bus_if.commit_valid = 1'b0;
      if (k == 2) begin
        bus_if.lookup_valid   = 1'b1;
        bus_if.lookup_rca_sel = 2'd0;
      end
      if (k == 3) begin
        bus_if.lookup_valid = 1'b0;
        chk("s2_wait_lov",
            32'(bus_if.lookup_out_valid), 1);
        chk("s2_wait_dst",
            32'(bus_if.lookup_dest_addrs), 0);
      end
      if (k == 7) busy = '0;
      if (bus_if.commit_ready) break;
    end
    chk("s2_latency", 32'(n), 9);
    chk("s2_dirty_post", 32'(dirty), 4'b0010);
    tick();
    lookup(2'd0);
    chk("s2_dst", 32'(bus_if.lookup_dest_addrs), 32'(D2));
    chk("s2_src", 32'(bus_if.lookup_src_addrs), 0);

    cfg_write(2'd3, 1'b0, 3'd0, 5'd31);
    chk("s3_dirty_pre", 32'(dirty), 4'b1010);
    bus_if.commit_valid   = 1'b1;
    bus_if.commit_rca_sel = 2'd3;
    tick();
    bus_if.commit_valid = 1'b0;
    tick();
    bus_if.lookup_valid   = 1'b1;
    bus_if.lookup_rca_sel = 2'd3;
    tick();
    chk("s3_copy_rdy", 32'(bus_if.commit_ready), 1);
    chk("s3_copy_src", 32'(bus_if.lookup_src_addrs), 0);
    tick();
    bus_if.lookup_valid = 1'b0;
    chk("s3_next_src", 32'(bus_if.lookup_src_addrs), 31);
    chk("s3_dirty_post", 32'(dirty), 4'b0010);
`else
    commit_wait(2'd1, n);
    chk("n1_latency", 32'(n), 1);
    chk("n1_cfgrdy_done", 32'(bus_if.cfg_ready), 0);
    tick();
    chk("n1_rdy_drop", 32'(bus_if.commit_ready), 0);
    chk("n1_cfgrdy_idle", 32'(bus_if.cfg_ready), 1);

    busy = 4'b0010;
    bus_if.cfg_rca_sel = 2'd1;
    #1;
    chk("n2_cfgrdy_busy", 32'(bus_if.cfg_ready), 0);
    bus_if.cfg_rca_sel = 2'd2;
    #1;
    chk("n2_cfgrdy_other", 32'(bus_if.cfg_ready), 1);
    cfg_write(2'd1, 1'b0, 3'd0, 5'd2);
    busy = '0;
    lookup(2'd1);
    chk("n2_src_kept", 32'(bus_if.lookup_src_addrs),
        32'(R1B));
    chk("n2_dirty", 32'(dirty), 0);
    cfg_write(2'd1, 1'b0, 3'd0, 5'd2);
    lookup(2'd1);
    chk("n2_src_new", 32'(bus_if.lookup_src_addrs),
        32'({5'd31, 5'd0, 5'd0, 5'd0, 5'd2}));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rca_reg_config_bank.md
# rca_reg_config_bank

Parametrised, double-buffered store of per-RCA CPU register address mappings (source read-port and destination write-port addresses) for the reconfigurable custom accelerator path. Config instructions write a staging bank. A commit handshake copies one RCA's staging entry into its active entry once that RCA is idle. Issue-side lookups read the active bank with one-cycle latency, so reconfiguration never disturbs an in-flight RCA use instruction.

## Interface
- NUM_RCAS, 4, number of accelerators (≥2)
- NUM_READ_PORTS, 5, source operand ports per RCA
- NUM_WRITE_PORTS, 2, destination ports per RCA
- REG_ADDR_W, 5, CPU register address width
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when cfg_valid & cfg_ready
- cfg_rca_sel  in  $clog2(NUM_RCAS)  target RCA
- cfg_src_dest  in  1  0 = source port, 1 = destination port
- cfg_port_sel  in  $clog2(max(NUM_READ_PORTS,NUM_WRITE_PORTS))  port index
- cfg_reg_addr  in  REG_ADDR_W  register address to store
- cfg_err  out  1  one-cycle pulse: accepted write had out-of-range port index
- commit_valid  in  1  request to activate staging entry
- commit_rca_sel  in  $clog2(NUM_RCAS)  RCA to commit
- commit_ready  out  1  one-cycle pulse when copy completed
- rca_busy  in  NUM_RCAS  per-RCA in-flight use flag
- dirty  out  NUM_RCAS  staging differs from active (written since last commit)
- lookup_valid  in  1  issue lookup request
- lookup_rca_sel  in  $clog2(NUM_RCAS)  RCA looked up
- lookup_out_valid  out  1  registered lookup valid
- lookup_src_addrs  out  NUM_READ_PORTS*REG_ADDR_W  active source addresses, port 0 in LSBs
- lookup_dest_addrs  out  NUM_WRITE_PORTS*REG_ADDR_W  active destination addresses, port 0 in LSBs

## Operation
- Storage: staging[NUM_RCAS] and active[NUM_RCAS], each holding NUM_READ_PORTS source and NUM_WRITE_PORTS destination addresses.
- Config write (cfg_valid & cfg_ready):
  - Updates the selected staging field at the clock edge and sets dirty[cfg_rca_sel].
  - If port_sel ≥ NUM_READ_PORTS (src) or ≥ NUM_WRITE_PORTS (dest): no update, dirty unchanged, cfg_err pulses the next cycle.
- cfg_ready = 1 only in IDLE.
- Commit FSM states: IDLE, WAIT, COPY, DONE.
  - IDLE: on commit_valid, latch commit_rca_sel and go to WAIT. A config write accepted in the same cycle is included in the commit.
  - WAIT: remain while rca_busy[latched] = 1. Otherwise go to COPY.
  - COPY: active[latched] ← staging[latched], clear dirty[latched], go to DONE.
  - DONE: commit_ready = 1 for one cycle, return to IDLE.
- commit_valid is ignored outside IDLE. A commit of a non-dirty RCA still traverses all states.
- Lookup: on lookup_valid, the active entry is registered to the outputs. Outputs hold their last value when lookup_valid = 0. lookup_out_valid follows lookup_valid delayed by one cycle.
- Lookup and COPY on the same RCA in the same cycle: the lookup returns pre-copy values.

## Timing
- Reset (rst = 0, asynchronous): every staging and active field is 0, dirty = 0, FSM = IDLE, cfg_ready = 1, cfg_err = 0, commit_ready = 0, lookup_out_valid = 0, lookup address outputs = 0.
- Reset release takes effect at the first rising clk edge with rst = 1.
- Reset asserted mid-commit aborts the commit; active is left at reset values.
- Config write: staging visible to a commit starting the next cycle.
- Commit latency with rca_busy = 0: request in cycle N, COPY in N+2, commit_ready in N+3, cfg_ready high again in N+4.
- Each busy cycle in WAIT adds one cycle of latency. Waiting is unbounded.
- Lookup latency: 1 cycle. Back-to-back lookups are supported every cycle.

## Configuration
- RCA_CFG_SHADOW_EN defined: double-buffered behaviour exactly as above.
- RCA_CFG_SHADOW_EN undefined:
  - Staging storage is removed and config writes update active directly.
  - dirty is constant 0.
  - commit_valid in IDLE produces commit_ready the next cycle, with no WAIT and no copy.
  - cfg_ready is additionally gated low while rca_busy[cfg_rca_sel] = 1.

## Test plan
- Reset mid-WAIT (rca_busy[1]=1) -> commit aborted; all outputs at reset values; cfg_ready = 1 after release.
- Write RCA2 src port3 = 5'd17, commit RCA2 with busy low, lookup RCA2 -> commit_ready 3 cycles after request; lookup_src_addrs[19:15] = 17; dirty[2] 1→0.
- Write RCA0 dest port1 = 5'd9, commit while rca_busy[0]=1 for 6 cycles -> commit_ready exactly 9 cycles after request; lookups during WAIT return old value 0.
- Write src port_sel = 6 with NUM_READ_PORTS=5 -> cfg_err one-cycle pulse; staging and dirty unchanged.
- Lookup RCA3 in the same cycle as COPY of RCA3 (new addr 5'd31) -> old value returned; next lookup returns 31.
- RCA_CFG_SHADOW_EN undefined: write RCA1 src port0 = 5'd4, lookup next cycle -> 4 with no commit; write with rca_busy[1]=1 -> cfg_ready = 0.
